// File: rtl/seg7_pkg.sv
// Shared types, glyph table and helpers for the multiplexed 7-segment display driver.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_OFF = 7'h00;

    // Segment order {G,F,E,D,C,B,A}; b and d use lowercase glyphs.
    localparam seg_t SEG_LUT [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [7:0] onehot(input int unsigned idx, input int unsigned digits);
        logic [7:0] oh;
        oh = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i == idx && i < digits) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to segment-pattern lookup.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output seg_t       seg_o
);

    assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment scan driver with frame-synchronous double buffering,
// leading-zero suppression, per-digit blanking and an anti-ghosting guard interval.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS         = 4,
    parameter int DIV            = 16,
    parameter int GUARD          = 4,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int LZ_BLANK       = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  dp_out,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_start
);

    localparam int                IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIV-1:0]    GUARD_C  = DIV'(GUARD);
    localparam seg_t              SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic              DP_IDLE  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [DIV-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]     act_val_q, act_val_d, pend_val_q, pend_val_d;
    logic [DIGITS-1:0]       act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]       act_blank_q, act_blank_d, pend_blank_q, pend_blank_d;
    logic                    pend_vld_q, pend_vld_d;
    seg_t                    seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [DIGITS-1:0]       an_q, an_d;
    logic                    fs_q, fs_d;

    logic                    wrap, frame_wrap, guard;
    logic [3:0]              nib;
    seg_t                    dec_seg, seg_lit;
    logic                    dp_lit;
    logic [DIGITS-1:0]       lz_sup;
    logic                    zero_run;
    logic [7:0]              oh_full;

    seg7_decode u_decode (
        .nib_i (nib),
        .seg_o (dec_seg)
    );

    // A digit is suppressed when it and every more significant nibble are zero.
    always_comb begin
        lz_sup   = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_run  = zero_run && (act_val_q[4*i +: 4] == 4'h0);
            lz_sup[i] = (LZ_BLANK != 0) && zero_run;
        end
    end

    always_comb begin
        wrap       = &cnt_q;
        frame_wrap = wrap && (idx_q == LAST_IDX);
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        if (wrap) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

        act_val_d    = act_val_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_vld_d   = pend_vld_q;
        if (load) begin
            pend_val_d   = value;
            pend_dp_d    = dp;
            pend_blank_d = blank;
            pend_vld_d   = 1'b1;
        end
        // A load landing on the frame wrap bypasses pending and commits at once.
        if (frame_wrap) begin
            if (load) begin
                act_val_d   = value;
                act_dp_d    = dp;
                act_blank_d = blank;
                pend_vld_d  = 1'b0;
            end else if (pend_vld_q) begin
                act_val_d   = pend_val_q;
                act_dp_d    = pend_dp_q;
                act_blank_d = pend_blank_q;
                pend_vld_d  = 1'b0;
            end
        end
        fs_d = frame_wrap;

        nib     = act_val_q[{idx_q, 2'b00} +: 4];
        seg_lit = (act_blank_q[idx_q] || lz_sup[idx_q]) ? SEG_OFF : dec_seg;
        dp_lit  = !act_blank_q[idx_q] && act_dp_q[idx_q];
        oh_full = onehot(32'(idx_q), DIGITS);
        guard   = (cnt_q < GUARD_C);

        seg_d = guard ? SEG_OFF : seg_lit;
        dp_d  = guard ? 1'b0 : dp_lit;
        an_d  = guard ? '0 : oh_full[DIGITS-1:0];
        if (SEG_ACTIVE_LOW != 0) begin
            seg_d = ~seg_d;
            dp_d  = ~dp_d;
        end
        if (AN_ACTIVE_LOW != 0) an_d = ~an_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            act_val_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_vld_q   <= 1'b0;
            seg_q        <= SEG_IDLE;
            dp_q         <= DP_IDLE;
            an_q         <= AN_IDLE;
            fs_q         <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_val_q    <= act_val_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_vld_q   <= pend_vld_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            fs_q         <= fs_d;
        end
    end

    assign seg         = seg_q;
    assign dp_out      = dp_q;
    assign an          = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: scan order, guard, double buffering, dp/blank, reset.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        load;
    logic [6:0]  seg;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    seg7_scan_driver #(
        .DIGITS(4), .DIV(4), .GUARD(2),
        .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1), .LZ_BLANK(1)
    ) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .blank(blank), .load(load),
        .seg(seg), .dp_out(dp_out), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [12:0] obs, input logic [12:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed {an,seg,dp,fs}=%b required=%b", tag, obs, exp);
        end
    endtask

    // Checks one full 64-cycle frame starting from state cnt=0, idx=0. The last
    // cycle of the frame is where the next frame_start is expected. Optionally
    // raises load after tick ld_at so the following edge captures it.
    task automatic check_frame(input int fr,
                               input logic [6:0] s0, input logic [6:0] s1,
                               input logic [6:0] s2, input logic [6:0] s3,
                               input logic [3:0] dpe, input int ld_at,
                               input logic [15:0] lv, input logic [3:0] ldp,
                               input logic [3:0] lbl);
        logic [6:0]  s [4];
        logic [12:0] exp;
        logic        efs;
        int          t;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        t = 0;
        for (int d = 0; d < 4; d++) begin
            for (int k = 1; k <= 16; k++) begin
                tick();
                t++;
                efs = (t == 64);
                if (k <= 2) exp = {4'b1111, 7'h00, 1'b0, efs};
                else        exp = {~(4'(1) << d), s[d], dpe[d], efs};
                chk($sformatf("frame%0d digit%0d cyc%0d", fr, d, k),
                    {an, seg, dp_out, frame_start}, exp);
                if (t == ld_at) begin
                    value = lv; dp = ldp; blank = lbl; load = 1'b1;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; value = '0; dp = '0; blank = '0; load = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("reset%0d", i), {an, seg, dp_out, frame_start}, {4'b1111, 7'h00, 1'b0, 1'b0});
        end
        rst = 1'b0;

        // Empty buffer: digit 0 shows 0, others suppressed; 1234 goes to pending.
        value = 16'h1234; load = 1'b1;
        check_frame(1, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, -1, '0, '0, '0);
        // 1234 shown; 00A0 loaded mid-frame must not tear.
        check_frame(2, 7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000, 30, 16'h00A0, 4'b0000, 4'b0000);
        // 00A0 shown; FFFF loaded exactly on the frame wrap cycle.
        check_frame(3, 7'h3F, 7'h77, 7'h00, 7'h00, 4'b0000, 63, 16'hFFFF, 4'b0000, 4'b0000);
        check_frame(4, 7'h71, 7'h71, 7'h71, 7'h71, 4'b0000, 20, 16'h8888, 4'b0010, 4'b0100);
        // dp on digit 1, blank on digit 2.
        check_frame(5, 7'h7F, 7'h7F, 7'h00, 7'h7F, 4'b0010, 10, 16'h0005, 4'b1000, 4'b0000);
        // Suppressed digit 3 still honours its dp.
        check_frame(6, 7'h6D, 7'h00, 7'h00, 7'h00, 4'b1000, -1, '0, '0, '0);

        // Park pending data, then reset while idx=2.
        for (int i = 1; i <= 37; i++) begin
            tick();
            if (i == 5) begin
                value = 16'h9999; dp = 4'b1111; blank = 4'b0000; load = 1'b1;
            end
        end
        rst = 1'b1;
        tick();
        chk("midreset", {an, seg, dp_out, frame_start}, {4'b1111, 7'h00, 1'b0, 1'b0});
        rst = 1'b0;
        check_frame(7, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, -1, '0, '0, '0);
        check_frame(8, 7'h3F, 7'h00, 7'h00, 7'h00, 4'b0000, -1, '0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
